// File: rtl/serial_acc_mc.sv
// rtl/serial_acc_mc.sv - multi-channel serial-load accumulator (optional saturation: SERIAL_ACC_SAT_EN)
module serial_acc_mc #(
    parameter int SHIFT_W = 33,
    parameter int ACC_W   = 128,
    parameter int NUM_CH  = 4,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              add,
    input  logic              clear,
    input  logic              sub,
    input  logic [CH_W-1:0]   ch,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [ACC_W-1:0]  big,
    output logic [NUM_CH-1:0] ovf,
    output logic              done,
    output logic              busy
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
    logic                cur_sub_q, cur_sub_d;
    logic [ACC_W-1:0]    acc_q [NUM_CH];
    logic [ACC_W-1:0]    acc_d [NUM_CH];
    logic [NUM_CH-1:0]   ovf_q, ovf_d;
    logic                done_q, done_d;

    logic [SHIFT_W:0]    shift_in;
    logic [ACC_W-1:0]    operand;
    logic [ACC_W-1:0]    acc_sel;
    logic [ACC_W:0]      sum;
    logic                ch_ok;
    logic                cur_ok;

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign ovf  = ovf_q;

    // Next-state, shift register, and commit arithmetic for the selected channel
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cur_ch_d  = cur_ch_q;
        cur_sub_d = cur_sub_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        // The concatenation is one bit wider than the register; keeping the low
        // SHIFT_W bits drops the oldest bit and also works for SHIFT_W == 1.
        shift_in = {shift_q, rx};
        operand  = ACC_W'(shift_q);
        ch_ok    = (int'(ch) < NUM_CH);
        cur_ok   = (int'(cur_ch_q) < NUM_CH);
        acc_sel  = '0;
        if (cur_ok) begin
            acc_sel = acc_q[cur_ch_q];
        end
        // Bit ACC_W is the carry on add and the borrow on subtract
        if (cur_sub_q) begin
            sum = {1'b0, acc_sel} - {1'b0, operand};
        end else begin
            sum = {1'b0, acc_sel} + {1'b0, operand};
        end

        case (state_q)
            IDLE: begin
                if (add && !clear) begin
                    shift_d   = shift_in[SHIFT_W-1:0];
                    cur_ch_d  = ch;
                    cur_sub_d = sub;
                    state_d   = SHIFT;
                end else if (add && clear) begin
                    shift_d = '0;
                end else if (clear && ch_ok) begin
                    acc_d[ch] = '0;
                    ovf_d[ch] = 1'b0;
                end
            end
            SHIFT: begin
                if (add) begin
                    shift_d = shift_in[SHIFT_W-1:0];
                end else begin
                    shift_d = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (cur_ok) begin
                        acc_d[cur_ch_q] = sum[ACC_W-1:0];
                        if (sum[ACC_W]) begin
                            ovf_d[cur_ch_q] = 1'b1;
`ifdef SERIAL_ACC_SAT_EN
                            acc_d[cur_ch_q] = cur_sub_q ? '0 : '1;
`endif
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partially shifted word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cur_ch_q  <= '0;
            cur_sub_q <= 1'b0;
            acc_q     <= '{default: '0};
            ovf_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cur_ch_q  <= cur_ch_d;
            cur_sub_q <= cur_sub_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    // Readout mux; an unmatched rd_ch reads zero
    always_comb begin
        big = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                big = acc_q[i];
            end
        end
    end

endmodule

// File: tb/tb_serial_acc_mc.sv
// tb/tb_serial_acc_mc.sv - directed scoreboard bench for serial_acc_mc
module tb_serial_acc_mc;

    localparam int SW = 33;
    localparam int AW = 128;
    localparam int NC = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b0;
    logic          add = 1'b0;
    logic          clear = 1'b0;
    logic          sub = 1'b0;
    logic [CW-1:0] ch = '0;
    logic [CW-1:0] rd_ch = '0;
    logic [AW-1:0] big;
    logic [NC-1:0] ovf;
    logic          done;
    logic          busy;

    typedef struct {
        int            c;
        logic [AW-1:0] acc;
        logic          ov;
    } exp_t;

    exp_t          sb[$];
    logic [AW-1:0] m_acc [NC];
    logic [NC-1:0] m_ovf;
    int            errors = 0;
    int            checks = 0;

    serial_acc_mc #(.SHIFT_W(SW), .ACC_W(AW), .NUM_CH(NC)) dut (
        .clk(clk), .rst(rst), .rx(rx), .add(add), .clear(clear), .sub(sub),
        .ch(ch), .rd_ch(rd_ch), .big(big), .ovf(ovf), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive an n-bit word MSB-first, model the commit, then check the result
    task automatic send(input int c, input bit s, input int n, input logic [63:0] v);
        logic [63:0]   w;
        logic [AW:0]   t;
        exp_t          e;
        exp_t          got_e;
        int            busy_cnt;
        w = (n >= 64) ? v : (v & ((64'd1 << n) - 64'd1));
        w = w & ((64'd1 << SW) - 64'd1);
        if (s) t = {1'b0, m_acc[c]} - {1'b0, AW'(w)};
        else   t = {1'b0, m_acc[c]} + {1'b0, AW'(w)};
        m_acc[c] = t[AW-1:0];
        if (t[AW]) begin
            m_ovf[c] = 1'b1;
`ifdef SERIAL_ACC_SAT_EN
            m_acc[c] = s ? '0 : '1;
`endif
        end
        e.c = c; e.acc = m_acc[c]; e.ov = m_ovf[c];
        sb.push_back(e);

        ch = CW'(c); rd_ch = CW'(c); sub = s;
        busy_cnt = 0;
        for (int i = n - 1; i >= 0; i--) begin
            add = 1'b1;
            rx = v[i];
            tick();
            if (busy === 1'b1) busy_cnt++;
        end
        add = 1'b0;
        rx = 1'b1;
        sub = ~s;
        tick();
        chk("busy_cycles", AW'(busy_cnt), AW'(n));
        chk("done_pulse", AW'(done), AW'(1));
        chk("busy_idle", AW'(busy), AW'(0));
        if (sb.size() > 0) begin
            got_e = sb.pop_front();
            rd_ch = CW'(got_e.c);
            #1;
            chk("big_commit", big, got_e.acc);
            chk("ovf_commit", AW'(ovf[got_e.c]), AW'(got_e.ov));
        end else begin
            chk("scoreboard_empty", AW'(1), AW'(0));
        end
        rx = 1'b0;
        tick();
        chk("done_once", AW'(done), AW'(0));
    endtask

    task automatic clr(input int c);
        ch = CW'(c);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_acc[c] = '0;
        m_ovf[c] = 1'b0;
        rd_ch = CW'(c);
        #1;
        chk("clear_acc", big, '0);
        chk("clear_ovf", AW'(ovf[c]), AW'(0));
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NC; i++) begin
            rd_ch = CW'(i);
            #1;
            chk(tag, big, m_acc[i]);
        end
        chk({tag, "_ovf"}, AW'(ovf), AW'(m_ovf));
    endtask

    initial begin
        for (int i = 0; i < NC; i++) m_acc[i] = '0;
        m_ovf = '0;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_done", AW'(done), AW'(0));
        chk("rst_busy", AW'(busy), AW'(0));
        check_all("rst_acc");

        // Single 8-bit word to channel 0
        send(0, 1'b0, 8, 64'hA5);

        // Two adds and a subtract on channel 2, others untouched
        send(2, 1'b0, 8, 64'hA5);
        send(2, 1'b0, 8, 64'hA5);
        send(2, 1'b1, 8, 64'h05);
        chk("ch2_value", m_acc[2], AW'(128'h145));
        check_all("multi_ch");

        // Borrow then carry on channel 1, then clear
        send(1, 1'b1, 8, 64'h01);
        send(1, 1'b0, 8, 64'h02);
        clr(1);

        // Word longer than the shift register: oldest bits drop out
        send(3, 1'b0, 35, 64'h5_8000_0001);
        chk("trunc_value", m_acc[3], AW'(128'h1_8000_0001));

        // add+clear together in IDLE only zeroes the shift register
        add = 1'b1; clear = 1'b1; rx = 1'b1; ch = 2'd0;
        tick();
        add = 1'b0; clear = 1'b0; rx = 1'b0;
        tick();
        chk("ac11_busy", AW'(busy), AW'(0));
        chk("ac11_done", AW'(done), AW'(0));
        check_all("ac11_acc");
        send(0, 1'b0, 4, 64'h3);

        // Reset mid-word discards the partial word
        ch = 2'd3; sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            add = 1'b1; rx = 1'b1;
            tick();
        end
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", AW'(busy), AW'(0));
        add = 1'b0; rx = 1'b0;
        #1 rst = 1'b0;
        for (int i = 0; i < NC; i++) m_acc[i] = '0;
        m_ovf = '0;
        tick();
        chk("midrst_done", AW'(done), AW'(0));
        check_all("midrst_acc");
        send(3, 1'b0, 8, 64'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
